// File: rtl/update_issuer_pkg.sv
// rtl/update_issuer_pkg.sv - shared types for the graph-update issuer
// Purpose: FSM state encoding, update record and field widths shared by
//          update_issuer, update_fifo and update_issuer_if.
// Ports:   none (package).
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

package update_issuer_pkg;

  // Const.vh macros give the MSB index, so field widths are one more.
  localparam int PRED_W   = `PRED_WIDTH + 1;
  localparam int WEIGHT_W = `WEIGHT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_CLR  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [PRED_W-1:0]   src;
    logic [PRED_W-1:0]   dst;
    logic [WEIGHT_W-1:0] e;
  } update_t;

endpackage

// File: rtl/update_issuer_if.sv
// rtl/update_issuer_if.sv - front-end and container signal bundle
// Purpose: groups the update intake handshake, the container launch/done
//          pair and the status outputs of update_issuer.
// Signals: in_valid/in_ready/in_src/in_dst/in_e (intake), container_reset,
//          u_src/u_dst/u_e, container_done (container side), busy,
//          issued_count, timeout_err (status).
// Modports: master = update_issuer, slave = front end / container side.
interface update_issuer_if;
  import update_issuer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [PRED_W-1:0]   in_src;
  logic [PRED_W-1:0]   in_dst;
  logic [WEIGHT_W-1:0] in_e;
  logic                container_reset;
  logic [PRED_W-1:0]   u_src;
  logic [PRED_W-1:0]   u_dst;
  logic [WEIGHT_W-1:0] u_e;
  logic                container_done;
  logic                busy;
  logic [15:0]         issued_count;
  logic                timeout_err;

  modport master (
    input  in_valid, in_src, in_dst, in_e, container_done,
    output in_ready, container_reset, u_src, u_dst, u_e,
           busy, issued_count, timeout_err
  );

  modport slave (
    output in_valid, in_src, in_dst, in_e, container_done,
    input  in_ready, container_reset, u_src, u_dst, u_e,
           busy, issued_count, timeout_err
  );
endinterface

// File: rtl/update_fifo.sv
// rtl/update_fifo.sv - synchronous FIFO of pending edge updates
// Purpose: DEPTH-entry queue of update_t between the front end and the FSM.
// Ports:   clk, reset_n (sync, active-low); i_push/i_wdata write side;
//          i_pop/o_rdata read side (o_rdata is the head, valid when !o_empty);
//          o_full, o_empty, o_count status.
module update_fifo
  import update_issuer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  update_t                i_wdata,
  input  logic                   i_pop,
  output update_t                o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  update_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full refuses a push regardless of a same-cycle pop.
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/update_issuer.sv
// rtl/update_issuer.sv - issues queued edge updates to the arbitrage container
// Purpose: buffers front-end updates and runs them through the container one
//          at a time (present update, pulse container_reset, wait for done),
//          dropping a run that exceeds TIMEOUT cycles in WAIT_DONE.
// Ports:   clk, reset_n (sync, active-low); bus (update_issuer_if.master)
//          carrying intake handshake, container interface and status.
module update_issuer
  import update_issuer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2**20
) (
  input  logic           clk,
  input  logic           reset_n,
  update_issuer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t                 r_state;
  state_t                 w_next;
  update_t                r_u;
  update_t                w_head;
  update_t                w_in;
  logic [WD_W-1:0]        r_wdog;
  logic [15:0]            r_issued;
  logic                   r_timeout_err;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_load;
  logic                   w_pop;
  logic                   w_complete;
  logic                   w_expire;

  assign w_in = '{src: bus.in_src, dst: bus.in_dst, e: bus.in_e};

  update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (bus.in_valid),
    .i_wdata (w_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // container_done is not looked at before WAIT_DONE: the level left over
  // from the previous run only clears once the container sees the pulse.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_pop      = 1'b0;
    w_complete = 1'b0;
    w_expire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load = 1'b1;
          w_next = LAUNCH;
        end
      end
      LAUNCH:   w_next = WAIT_CLR;
      WAIT_CLR: w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.container_done) begin
          w_pop      = 1'b1;
          w_complete = 1'b1;
          w_next     = IDLE;
        end else if (r_wdog == WD_LAST) begin
          w_pop    = 1'b1;
          w_expire = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // r_u only loads on IDLE->LAUNCH, so the update stays put for the
  // container until after the pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_u           <= '0;
      r_wdog        <= '0;
      r_issued      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_load) r_u <= w_head;
      if (r_state == WAIT_CLR) begin
        r_wdog <= '0;
      end else if (r_state == WAIT_DONE) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_complete) r_issued <= r_issued + 16'd1;
      if (w_expire)   r_timeout_err <= 1'b1;
    end
  end

  assign bus.in_ready        = !w_full;
  assign bus.container_reset = (r_state == LAUNCH);
  assign bus.u_src           = r_u.src;
  assign bus.u_dst           = r_u.dst;
  assign bus.u_e             = r_u.e;
  assign bus.busy            = (r_state != IDLE) || (w_count != '0);
  assign bus.issued_count    = r_issued;
  assign bus.timeout_err     = r_timeout_err;
endmodule

// File: tb/tb_update_issuer.sv
// tb/tb_update_issuer.sv - scoreboard bench for update_issuer
module tb_update_issuer;
  import update_issuer_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  update_issuer_if bus();

  update_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int      n_checks = 0;
  int      n_err = 0;
  update_t q_launch[$];
  update_t exp_u = '0;
  int      n_pulses = 0;
  int      last_pulse_cyc = 0;
  int      last_issue_cyc = 0;
  int      last_err_cyc = 0;
  int      last_done_cyc = 0;
  int      done_delay = 10;
  bit      stale_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event did not occur within its bound (cycle %0d)", name, cyc);
  endtask

  // Container model: done rises done_delay cycles after the pulse (never when
  // done_delay is 0). In stale_mode the old done level is held for two more
  // cycles after the pulse instead of being cleared by it.
  initial begin : container_model
    int cnt;
    int hold;
    cnt = 0;
    hold = 0;
    bus.container_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cnt = 0;
        hold = 0;
      end else if (bus.container_reset) begin
        if (stale_mode) hold = 2;
        else bus.container_done = 1'b0;
        cnt = done_delay;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) bus.container_done = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.container_done = 1'b1;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  // Monitor: every launch is checked against the scoreboard queue; between
  // launches the presented update must not move.
  initial begin : monitor
    logic        prev_cr;
    logic [15:0] prev_issued;
    logic        prev_err;
    update_t     act;
    prev_cr = 1'b0;
    prev_issued = '0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      act = '{src: bus.u_src, dst: bus.u_dst, e: bus.u_e};
      if (!reset_n) begin
        exp_u = '0;
        prev_cr = 1'b0;
      end else begin
        if (bus.container_reset) begin
          check("reset_pulse_single_cycle", {63'd0, prev_cr}, 64'd0);
          if (q_launch.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_launch: got launch of 0x%0h, expected none (cycle %0d)", act, cyc);
          end else begin
            exp_u = q_launch.pop_front();
            check("launch_update", {32'd0, act}, {32'd0, exp_u});
          end
          n_pulses++;
          last_pulse_cyc = cyc;
        end else begin
          check("u_stable", {32'd0, act}, {32'd0, exp_u});
        end
        prev_cr = bus.container_reset;
      end
      if (bus.issued_count != prev_issued) last_issue_cyc = cyc;
      if (bus.timeout_err && !prev_err) last_err_cyc = cyc;
      prev_issued = bus.issued_count;
      prev_err = bus.timeout_err;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [PRED_W-1:0] s, input logic [PRED_W-1:0] d,
                      input logic [WEIGHT_W-1:0] e, output int acc_at);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    acc_at = -1;
    bus.in_valid = 1'b1;
    bus.in_src = s;
    bus.in_dst = d;
    bus.in_e = e;
    while (!acc && g < 300) begin
      if (bus.in_ready) begin
        acc = 1'b1;
        acc_at = cyc;
      end
      @(negedge clk);
      g++;
    end
    bus.in_valid = 1'b0;
    if (acc) q_launch.push_back('{src: s, dst: d, e: e});
    else fail("push_accept");
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (bus.busy && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) fail("wait_idle");
  endtask

  task automatic wait_pulse(input int np0);
    int g;
    g = 0;
    while (n_pulses == np0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (n_pulses == np0) fail("wait_pulse");
  endtask

  initial begin : stimulus
    int acc_cyc;
    int np0;
    int a_pulse;
    bus.in_valid = 1'b0;
    bus.in_src = '0;
    bus.in_dst = '0;
    bus.in_e = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_container_reset", {63'd0, bus.container_reset}, 64'd0);
    check("rst_u", {32'd0, bus.u_src, bus.u_dst, bus.u_e}, 64'd0);
    check("rst_issued", {48'd0, bus.issued_count}, 64'd0);
    check("rst_timeout_err", {63'd0, bus.timeout_err}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single update: pulse in cycle 2 after the accepting edge only
    done_delay = 10;
    push(8'd3, 8'd5, 16'h1234, acc_cyc);
    check("single_cycle1_no_pulse", {63'd0, bus.container_reset}, 64'd0);
    check("single_busy", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    check("single_cycle2_pulse", {63'd0, bus.container_reset}, 64'd1);
    check("single_cycle2_u", {32'd0, bus.u_src, bus.u_dst, bus.u_e}, 64'h0305_1234);
    @(negedge clk);
    check("single_cycle3_no_pulse", {63'd0, bus.container_reset}, 64'd0);
    wait_idle(100);
    check("single_issued", {48'd0, bus.issued_count}, 64'd1);
    check("single_pop_at_done", last_issue_cyc, last_done_cyc + 1);
    check("single_no_err", {63'd0, bus.timeout_err}, 64'd0);

    // Full FIFO: 8 accepted, 9th waits for the first pop
    for (int i = 0; i < 8; i++) begin
      push(8'(16 + i), 8'(32 + i), 16'(16'h1000 + i), acc_cyc);
    end
    check("full_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    push(8'd24, 8'd40, 16'h1008, acc_cyc);
    check("full_ninth_accept_cycle", acc_cyc, last_done_cyc + 1);
    wait_idle(500);
    check("full_issued", {48'd0, bus.issued_count}, 64'd10);
    check("full_queue_drained", q_launch.size(), 0);

    // Stale done held across LAUNCH and WAIT_CLR
    stale_mode = 1'b1;
    push(8'd50, 8'd51, 16'h5555, acc_cyc);
    wait_idle(100);
    stale_mode = 1'b0;
    check("stale_issued", {48'd0, bus.issued_count}, 64'd11);
    check("stale_pop_at_new_done", last_issue_cyc, last_done_cyc + 1);

    // Done coincides with watchdog expiry (16th WAIT_DONE cycle)
    done_delay = 17;
    push(8'd60, 8'd61, 16'h6666, acc_cyc);
    wait_idle(100);
    check("coincide_issued", {48'd0, bus.issued_count}, 64'd12);
    check("coincide_no_err", {63'd0, bus.timeout_err}, 64'd0);
    check("coincide_pop_at_done", last_issue_cyc, last_done_cyc + 1);

    // Timeout: first entry dropped after 16 WAIT_DONE cycles, second completes
    done_delay = 0;
    np0 = n_pulses;
    push(8'd70, 8'd71, 16'hAAAA, acc_cyc);
    push(8'd72, 8'd73, 16'hBBBB, acc_cyc);
    wait_pulse(np0);
    a_pulse = last_pulse_cyc;
    done_delay = 10;
    wait_idle(300);
    check("timeout_err_sticky", {63'd0, bus.timeout_err}, 64'd1);
    check("timeout_drop_cycle", last_err_cyc, a_pulse + 18);
    check("timeout_issued", {48'd0, bus.issued_count}, 64'd13);

    // Reset mid-run with entries queued
    done_delay = 0;
    np0 = n_pulses;
    push(8'd80, 8'd81, 16'hC0C0, acc_cyc);
    push(8'd82, 8'd83, 16'hC1C1, acc_cyc);
    push(8'd84, 8'd85, 16'hC2C2, acc_cyc);
    wait_pulse(np0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_container_reset", {63'd0, bus.container_reset}, 64'd0);
    check("midrst_u", {32'd0, bus.u_src, bus.u_dst, bus.u_e}, 64'd0);
    check("midrst_issued", {48'd0, bus.issued_count}, 64'd0);
    check("midrst_timeout_err", {63'd0, bus.timeout_err}, 64'd0);
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    q_launch.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_not_reissued", {63'd0, bus.busy}, 64'd0);
    done_delay = 10;
    push(8'd7, 8'd9, 16'hBEEF, acc_cyc);
    push(8'd1, 8'd2, 16'h0001, acc_cyc);
    wait_idle(200);
    check("post_rst_issued", {48'd0, bus.issued_count}, 64'd2);
    check("post_rst_no_err", {63'd0, bus.timeout_err}, 64'd0);
    check("post_rst_queue_drained", q_launch.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : global_bound
    #200000;
    fail("global_time_limit");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/update_issuer.md
# update_issuer

Initiator for the graph-update protocol consumed by the arbitrage container. It accepts edge-weight updates (`src`, `dst`, weight) from the keyboard/quote front end into a small FIFO. It then issues them to the container one at a time: it presents the update on `u_src`/`u_dst`/`u_e`, pulses `container_reset`, and holds the update stable until `container_done`. A watchdog drops an update whose run never completes and flags the error.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `TIMEOUT`, 2**20 — max cycles spent in WAIT_DONE before the entry is dropped.

Ports:
- `clk` in 1 — single clock; all logic on posedge.
- `reset_n` in 1 — synchronous, active-low reset.
- `in_valid` in 1 — front end offers an update this cycle.
- `in_ready` out 1 — FIFO can accept; transfer when `in_valid && in_ready`.
- `in_src` in [`PRED_WIDTH:0] — source vertex.
- `in_dst` in [`PRED_WIDTH:0] — destination vertex.
- `in_e` in [`WEIGHT_WIDTH:0] — edge weight, passed through unmodified.
- `container_reset` out 1 — one-cycle start pulse to the container.
- `u_src` out [`PRED_WIDTH:0] — update source presented to the container.
- `u_dst` out [`PRED_WIDTH:0] — update destination presented to the container.
- `u_e` out [`WEIGHT_WIDTH:0] — update weight presented to the container.
- `container_done` in 1 — container run complete; level, cleared by the container on `container_reset`.
- `busy` out 1 — FSM not in IDLE, or FIFO non-empty.
- `issued_count` out 16 — completed runs; wraps modulo 2^16.
- `timeout_err` out 1 — sticky; set on any watchdog expiry.

## Operation
- FIFO:
  - Push on `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`, computed from the registered count.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - An offered update is never lost while `in_ready=0`. The front end holds it.
- FSM states:
  - IDLE: if FIFO non-empty, latch the head into `u_src`/`u_dst`/`u_e` → LAUNCH. Otherwise stay.
  - LAUNCH: `container_reset=1` for exactly this cycle → WAIT_CLR.
  - WAIT_CLR: `container_done` ignored (it may be stale from the previous run) → WAIT_DONE. Clear the watchdog counter.
  - WAIT_DONE:
    - Increment the watchdog each cycle.
    - If `container_done=1`: pop the FIFO, `issued_count += 1`, → IDLE.
    - Else if the watchdog reaches `TIMEOUT-1`: pop the FIFO (entry dropped), set `timeout_err`, → IDLE. `issued_count` is unchanged.
    - `container_done` wins over expiry in the same cycle.
- `u_*` change only on the IDLE→LAUNCH transition. They are stable from LAUNCH until the cycle after the pop.
- A push and a pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- Reset (`reset_n=0` at an edge) takes effect from any state, including mid-run:
  - state=IDLE, FIFO emptied, counters 0.
  - `container_reset=0`, `u_*=0`, `issued_count=0`, `timeout_err=0`, `busy=0`, `in_ready=1`.
  - A container run in progress is abandoned and not re-issued.

## Timing
- Push accepted at edge 0 into an empty FIFO with FSM in IDLE:
  - cycle 1: IDLE sees non-empty.
  - cycle 2: LAUNCH, `container_reset=1`, `u_*` valid.
  - cycle 3: WAIT_CLR (the container writes its matrix at the end of this cycle).
  - cycle 4 onward: WAIT_DONE.
- Done seen in cycle N: pop at edge N. The next LAUNCH is in cycle N+2 if the FIFO is still non-empty.
- Minimum issue period: 4 cycles plus the container run time.
- `in_ready` updates one cycle after the count changes.

## Structure
- Shared package: FSM state enum (`IDLE`, `LAUNCH`, `WAIT_CLR`, `WAIT_DONE`) and an update struct {src, dst, e} built on the `Const.vh` `PRED_WIDTH`/`WEIGHT_WIDTH` macros.
- One sub-module, `update_fifo`:
  - synchronous FIFO of the update struct, DEPTH entries;
  - push/pop, `full`/`empty`, count of width `$clog2(DEPTH)+1`.
- The FSM, watchdog and counters live in `update_issuer`.

## Test plan
- Single update: push (3,5,0x1234), container model asserts done 10 cycles after the pulse → `container_reset` high in cycle 2 only; `u_*`=(3,5,0x1234) held until the pop; `issued_count=1`.
- Full FIFO: with DEPTH=8 and done withheld, push 9 updates → `in_ready=0` after 8 accepted; the 9th is accepted the cycle after the first done; all 9 issued in order.
- Stale done: hold `container_done=1` through LAUNCH and WAIT_CLR, drop it at the pulse → no early pop; the run completes only on the next rising done.
- Timeout: TIMEOUT=16, done never asserted → the entry is dropped after 16 WAIT_DONE cycles; `timeout_err=1` and stays set; `issued_count=0`; the next entry launches normally.
- Done and expiry coincide: TIMEOUT=16, done asserted in the 16th WAIT_DONE cycle → counted as complete; `timeout_err` stays 0.
- Reset mid-run: `reset_n=0` during WAIT_DONE with 3 entries queued → next cycle IDLE, FIFO empty, all outputs at reset values; later pushes issue normally.
